sampled_counter: RTL and testbench

Parametrised up/down counter with a decimated sample register, the next generation of the team's counter-plus-capture blocks. It generalises count width and sample period, and adds load, direction, synchronous clear, a terminal-count pulse and an optional saturating mode. It sits between control logic and any consumer that needs a stable, periodically refreshed copy of a running count (`y`) alongside the live count.

---
 rtl/sampled_counter_pkg.sv | 12 +
 rtl/sample_divider.sv | 36 +++
 rtl/sampled_counter.sv | 94 +++++++++
 tb/tb_sampled_counter.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/sampled_counter_pkg.sv
// Shared constants and helpers for the sampled_counter block.
package sampled_counter_pkg;

  localparam logic CNT_UP   = 1'b1;
  localparam logic CNT_DOWN = 1'b0;

  // Phase register width; DIV = 1 still needs a one-bit register.
  function automatic int phase_width(input int div);
    return (div <= 1) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/sample_divider.sv
// Free-running sample phase counter; strobe_o is high while phase = DIV-1.
module sample_divider
  import sampled_counter_pkg::*;
#(
  parameter int DIV = 2
) (
  input  logic clock_i,
  input  logic reset_i,
  input  logic clr_i,
  output logic strobe_o
);

  localparam int PW = phase_width(DIV);
  localparam logic [PW-1:0] LAST = PW'(DIV - 1);
  localparam logic [PW-1:0] ONE  = PW'(1);

  logic [PW-1:0] phase_q, phase_d;

  assign strobe_o = (phase_q == LAST);

  always_comb begin
    phase_d = phase_q + ONE;
    if (clr_i || strobe_o) begin
      phase_d = '0;
    end
  end

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      phase_q <= '0;
    end else begin
      phase_q <= phase_d;
    end
  end

endmodule

// File: rtl/sampled_counter.sv
// Up/down counter with decimated sample register and terminal-count pulse.
// Define COUNTER_SAT_EN to make sat_i hold the count at its limits.
module sampled_counter
  import sampled_counter_pkg::*;
#(
  parameter int               WIDTH = 9,
  parameter int               DIV   = 2,
  parameter logic [WIDTH-1:0] INIT  = '0
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic             up_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             sat_i,
  output logic [WIDTH-1:0] count_o,
  output logic [WIDTH-1:0] y_o,
  output logic             y_valid_o,
  output logic             tc_o
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             y_valid_q, y_valid_d;
  logic             tc_q, tc_d;
  logic             strobe;
  logic             sat_hold;
  logic             at_limit;

`ifdef COUNTER_SAT_EN
  assign sat_hold = sat_i;
`else
  logic unused_sat;
  assign unused_sat = sat_i;
  assign sat_hold   = 1'b0;
`endif

  sample_divider #(.DIV(DIV)) u_div (
    .clock_i  (clock_i),
    .reset_i  (reset_i),
    .clr_i    (clr_i),
    .strobe_o (strobe)
  );

  // Sampling uses count_q, so a coincident load/step never leaks into y.
  always_comb begin
    count_d   = count_q;
    y_d       = y_q;
    y_valid_d = 1'b0;
    tc_d      = 1'b0;
    at_limit  = (up_i == CNT_UP) ? (count_q == CNT_MAX) : (count_q == '0);
    if (clr_i) begin
      count_d = INIT;
    end else begin
      if (strobe) begin
        y_d       = count_q;
        y_valid_d = 1'b1;
      end
      if (load_i) begin
        count_d = load_val_i;
      end else if (en_i) begin
        tc_d = at_limit;
        if (!(at_limit && sat_hold)) begin
          count_d = (up_i == CNT_UP) ? (count_q + ONE) : (count_q - ONE);
        end
      end
    end
  end

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      count_q   <= INIT;
      y_q       <= '0;
      y_valid_q <= 1'b0;
      tc_q      <= 1'b0;
    end else begin
      count_q   <= count_d;
      y_q       <= y_d;
      y_valid_q <= y_valid_d;
      tc_q      <= tc_d;
    end
  end

  assign count_o   = count_q;
  assign y_o       = y_q;
  assign y_valid_o = y_valid_q;
  assign tc_o      = tc_q;

endmodule

// File: tb/tb_sampled_counter.sv
// Bench for sampled_counter: two configurations driven by shared stimulus,
// checked every cycle against an arithmetic model plus literal expectations.
module tb_sampled_counter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clr, en, up, load, sat;
  logic [8:0] load_val;

  logic [8:0] count0, y0;
  logic       yv0, tc0;
  logic [5:0] count1, y1;
  logic       yv1, tc1;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  sampled_counter #(.WIDTH(9), .DIV(2), .INIT(9'd0)) dut0 (
    .clock_i(clk), .reset_i(rst_n), .clr_i(clr), .en_i(en), .up_i(up),
    .load_i(load), .load_val_i(load_val), .sat_i(sat),
    .count_o(count0), .y_o(y0), .y_valid_o(yv0), .tc_o(tc0)
  );

  sampled_counter #(.WIDTH(6), .DIV(5), .INIT(6'd5)) dut1 (
    .clock_i(clk), .reset_i(rst_n), .clr_i(clr), .en_i(en), .up_i(up),
    .load_i(load), .load_val_i(load_val[5:0]), .sat_i(sat),
    .count_o(count1), .y_o(y1), .y_valid_o(yv1), .tc_o(tc1)
  );

  // Model: counts edges since reset/clear; a sample happens on every DIV-th.
  int mw[2] = '{9, 6};
  int md[2] = '{2, 5};
  int mi[2] = '{0, 5};
  int m_count[2], m_y[2], m_edge[2], m_yv[2], m_tc[2];

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s at %0t: actual=%0d expected=%0d", nm, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_count[k] = mi[k]; m_y[k] = 0; m_yv[k] = 0; m_tc[k] = 0; m_edge[k] = 0;
    end
  endtask

  task automatic model_edge();
    int modv, old, nxt;
    bit hold;
    for (int k = 0; k < 2; k++) begin
      modv = 1 << mw[k];
      old  = m_count[k];
      m_yv[k] = 0;
      m_tc[k] = 0;
      if (clr) begin
        m_count[k] = mi[k];
        m_edge[k]  = 0;
      end else begin
        m_edge[k]++;
        if (m_edge[k] % md[k] == 0) begin
          m_y[k]  = old;
          m_yv[k] = 1;
        end
        if (load) begin
          m_count[k] = int'(load_val) % modv;
        end else if (en) begin
          nxt = up ? old + 1 : old - 1;
          if (nxt < 0 || nxt >= modv) begin
            m_tc[k] = 1;
`ifdef COUNTER_SAT_EN
            hold = sat;
`else
            hold = 0;
`endif
            nxt = hold ? old : (nxt + modv) % modv;
          end
          m_count[k] = nxt;
        end
      end
    end
  endtask

  always @(posedge clk) begin
    if (rst_n) model_edge();
    else       model_reset();
    #1;
    chk("count0",  int'(count0), m_count[0]);
    chk("y0",      int'(y0),     m_y[0]);
    chk("y_valid0", int'(yv0),   m_yv[0]);
    chk("tc0",     int'(tc0),    m_tc[0]);
    chk("count1",  int'(count1), m_count[1]);
    chk("y1",      int'(y1),     m_y[1]);
    chk("y_valid1", int'(yv1),   m_yv[1]);
    chk("tc1",     int'(tc1),    m_tc[1]);
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    rst_n = 1'b0; clr = 0; en = 0; up = 1; load = 0; sat = 0; load_val = '0;
    tick(3);
    chk("rst_count0", int'(count0), 0);
    chk("rst_y0", int'(y0), 0);
    chk("rst_yv0", int'(yv0), 0);
    chk("rst_count1", int'(count1), 5);

    rst_n = 1'b1; en = 1; up = 1;
    tick(); chk("up_c1", int'(count0), 1);
    tick(); chk("up_c2", int'(count0), 2); chk("up_y1", int'(y0), 1); chk("up_yv", int'(yv0), 1);
    tick(); chk("up_yv_low", int'(yv0), 0);
    tick(); chk("up_y3", int'(y0), 3);

    load = 1; load_val = 9'd511;
    tick(); chk("load511", int'(count0), 511);
    load = 0;
    tick(); chk("wrap_up_c", int'(count0), 0); chk("wrap_up_tc", int'(tc0), 1);
    tick(); chk("wrap_up_tc_off", int'(tc0), 0);
    up = 0;
    tick(); chk("down_c0", int'(count0), 0);
    tick(); chk("wrap_dn_c", int'(count0), 511); chk("wrap_dn_tc", int'(tc0), 1);
    tick(); chk("wrap_dn_tc_off", int'(tc0), 0); chk("down_c510", int'(count0), 510);

    clr = 1; load = 1; load_val = 9'd100;
    tick(); chk("clr_c0", int'(count0), 0); chk("clr_c1", int'(count1), 5); chk("clr_yv", int'(yv0), 0);
    clr = 0; load = 0; en = 0;
    tick(); chk("clr_e1_yv", int'(yv0), 0);
    tick(); chk("clr_e2_yv", int'(yv0), 1); chk("clr_e2_y", int'(y0), 0);

    sat = 1; load = 1; load_val = 9'd511;
    tick();
    load = 0; en = 1; up = 1;
`ifdef COUNTER_SAT_EN
    for (int i = 0; i < 3; i++) begin
      tick(); chk("sat_hold", int'(count0), 511); chk("sat_tc", int'(tc0), 1);
    end
`else
    tick(); chk("nosat_c0", int'(count0), 0); chk("nosat_tc", int'(tc0), 1);
    tick(); chk("nosat_c1", int'(count0), 1); chk("nosat_tc0", int'(tc0), 0);
    tick();
`endif
    sat = 0; en = 0; load = 1; load_val = 9'd42;
    tick();
    load = 0;
    tick(10); chk("div5_y", int'(y1), 42); chk("div5_c", int'(count1), 42);

    for (int i = 0; i < 400; i++) begin
      clr      = ($urandom_range(0, 24) == 0);
      load     = ($urandom_range(0, 9) == 0);
      en       = ($urandom_range(0, 3) != 0);
      up       = $urandom_range(0, 1) != 0;
      sat      = $urandom_range(0, 1) != 0;
      load_val = ($urandom_range(0, 3) == 0) ? 9'd511 : 9'($urandom_range(0, 511));
      tick();
    end

    clr = 0; load = 0; en = 0;
    tick(3);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_count0", int'(count0), 0); chk("arst_y0", int'(y0), 0);
    chk("arst_yv0", int'(yv0), 0); chk("arst_tc0", int'(tc0), 0);
    chk("arst_count1", int'(count1), 5); chk("arst_y1", int'(y1), 0);
    tick(2);
    rst_n = 1'b1;
    tick(4); chk("rel_yv1_early", int'(yv1), 0);
    tick();  chk("rel_yv1", int'(yv1), 1); chk("rel_y1", int'(y1), 5);
    tick(3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
